// File: rtl/dm_arbiter_if.sv
// Bundle of the two requester ports and the data-memory port of dm_arbiter.
// The arbiter connects through the slave modport; the requesters and the
// memory together form the master side.
// Handshake: a requester raises req with all fields stable and holds them
// until the cycle in which its ack is high; ack is a one-cycle pulse and
// rdata is valid only while ack is high (0 otherwise).
interface dm_arbiter_if #(
    parameter int AW = 10
);
    // Requester 0 (CPU load/store path)
    logic        req0;
    logic        we0;
    logic [31:0] addr0;
    logic [3:0]  be0;
    logic [31:0] wdata0;
    logic [31:0] pc0;
    logic        ack0;
    logic [31:0] rdata0;

    // Requester 1 (debug/DMA port)
    logic        req1;
    logic        we1;
    logic [31:0] addr1;
    logic [3:0]  be1;
    logic [31:0] wdata1;
    logic [31:0] pc1;
    logic        ack1;
    logic [31:0] rdata1;

    // Data memory side
    logic [31:0]   dm_pc;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [31:0]   dm_din;
    logic [31:0]   dm_dout;

    // Current FSM state, for observation only (IDLE=0, SERVE=1, ACK=2)
    logic [1:0]    fsm_state;

    modport slave (
        input  req0, we0, addr0, be0, wdata0, pc0,
        output ack0, rdata0,
        input  req1, we1, addr1, be1, wdata1, pc1,
        output ack1, rdata1,
        output dm_pc, dm_we, dm_addr, dm_din,
        input  dm_dout,
        output fsm_state
    );

    modport master (
        output req0, we0, addr0, be0, wdata0, pc0,
        input  ack0, rdata0,
        output req1, we1, addr1, be1, wdata1, pc1,
        input  ack1, rdata1,
        input  dm_pc, dm_we, dm_addr, dm_din,
        output dm_dout,
        input  fsm_state
    );
endinterface

// File: rtl/dm_arbiter.sv
// Two-requester round-robin arbiter for the single-port data memory.
// Each access takes IDLE -> SERVE -> ACK. Byte-enable stores are done as a
// read-modify-write inside the single SERVE cycle: the memory's combinational
// read data is merged with the write data and written back on the same edge.
module dm_arbiter #(
    parameter int AW = 10
) (
    input  logic         clk,
    input  logic         reset,
    dm_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        ACK   = 2'd2
    } state_t;

    state_t        state;
    logic          rr;          // requester with priority when both request
    logic          gnt_id;      // requester owning the current access
    logic          we_q;
    logic [3:0]    be_q;
    logic [31:0]   wdata_q;
    logic [31:0]   pc_q;
    logic [AW-1:0] addr_q;
    logic          we_pulse;    // high exactly during SERVE of a real write
    logic [31:0]   din_q;       // last merged word, held outside SERVE
    logic          ack0_q;
    logic          ack1_q;
    logic [31:0]   rdata0_q;
    logic [31:0]   rdata1_q;

    logic          gnt_valid;
    logic          gnt_sel;
    logic [31:0]   mask;
    logic [31:0]   merged;

    // Address bits outside the word index carry no meaning here.
    logic          unused_addr_bits;
    assign unused_addr_bits = ^{bus.addr0[31:AW+2], bus.addr0[1:0],
                                bus.addr1[31:AW+2], bus.addr1[1:0]};

    // Round-robin pick: a lone requester always wins, a tie goes to rr.
    always_comb begin
        gnt_valid = bus.req0 | bus.req1;
        gnt_sel   = 1'b0;
        if (bus.req0 && bus.req1) begin
            gnt_sel = rr;
        end else if (bus.req1) begin
            gnt_sel = 1'b1;
        end
    end

    // Byte-lane merge of the current memory word with the latched write data.
    always_comb begin
        mask   = {{8{be_q[3]}}, {8{be_q[2]}}, {8{be_q[1]}}, {8{be_q[0]}}};
        merged = (bus.dm_dout & ~mask) | (wdata_q & mask);
    end

    // Reset must block a write even if it lands on the SERVE edge, so the
    // registered write pulse is gated by reset itself.
    assign bus.dm_we     = we_pulse & ~reset;
    assign bus.dm_addr   = addr_q;
    assign bus.dm_pc     = pc_q;
    assign bus.dm_din    = (state == SERVE) ? merged : din_q;
    assign bus.ack0      = ack0_q;
    assign bus.ack1      = ack1_q;
    assign bus.rdata0    = rdata0_q;
    assign bus.rdata1    = rdata1_q;
    assign bus.fsm_state = state;

    // Access FSM: grant and latch in IDLE, memory access in SERVE, ack pulse in ACK.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            rr       <= 1'b0;
            gnt_id   <= 1'b0;
            we_q     <= 1'b0;
            be_q     <= 4'd0;
            wdata_q  <= 32'd0;
            pc_q     <= 32'd0;
            addr_q   <= '0;
            we_pulse <= 1'b0;
            din_q    <= 32'd0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            rdata0_q <= 32'd0;
            rdata1_q <= 32'd0;
        end else begin
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            rdata0_q <= 32'd0;
            rdata1_q <= 32'd0;
            we_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (gnt_valid) begin
                        gnt_id  <= gnt_sel;
                        rr      <= ~gnt_sel;
                        if (gnt_sel) begin
                            we_q     <= bus.we1;
                            be_q     <= bus.be1;
                            wdata_q  <= bus.wdata1;
                            pc_q     <= bus.pc1;
                            addr_q   <= bus.addr1[AW+1:2];
                            we_pulse <= bus.we1 & (|bus.be1);
                        end else begin
                            we_q     <= bus.we0;
                            be_q     <= bus.be0;
                            wdata_q  <= bus.wdata0;
                            pc_q     <= bus.pc0;
                            addr_q   <= bus.addr0[AW+1:2];
                            we_pulse <= bus.we0 & (|bus.be0);
                        end
                        state <= SERVE;
                    end
                end
                SERVE: begin
                    din_q <= merged;
                    // Read data is the word as it stood before any write.
                    if (gnt_id) begin
                        ack1_q   <= 1'b1;
                        rdata1_q <= bus.dm_dout;
                    end else begin
                        ack0_q   <= 1'b1;
                        rdata0_q <= bus.dm_dout;
                    end
                    state <= ACK;
                end
                ACK: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a behavioural 1024 x 32 data memory.
module tb_dm_arbiter;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    dm_arbiter_if #(.AW(10)) bus ();

    dm_arbiter #(.AW(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Data memory: combinational read, word write on the clock edge.
    logic [31:0] mem [0:1023];
    assign bus.dm_dout = mem[bus.dm_addr];
    always @(posedge clk) begin
        if (bus.dm_we) mem[bus.dm_addr] <= bus.dm_din;
    end

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int id, input logic req, input logic we,
                           input logic [31:0] addr, input logic [3:0] be,
                           input logic [31:0] wd, input logic [31:0] pc);
        if (id == 0) begin
            bus.req0 = req; bus.we0 = we; bus.addr0 = addr;
            bus.be0 = be; bus.wdata0 = wd; bus.pc0 = pc;
        end else begin
            bus.req1 = req; bus.we1 = we; bus.addr1 = addr;
            bus.be1 = be; bus.wdata1 = wd; bus.pc1 = pc;
        end
    endtask

    // One access, started from a negedge in IDLE; returns at a negedge in IDLE.
    task automatic access(input int id, input logic we, input logic [31:0] addr,
                          input logic [3:0] be, input logic [31:0] wd, input logic [31:0] pc,
                          output logic [31:0] rd, output int lat, output int we_cycles,
                          output logic [31:0] din_seen, output logic [31:0] pc_seen,
                          output logic [31:0] addr_seen);
        rd = 0; lat = 0; we_cycles = 0; din_seen = 0; pc_seen = 0; addr_seen = 0;
        set_req(id, 1'b1, we, addr, be, wd, pc);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (bus.dm_we) begin
                we_cycles++;
                din_seen  = bus.dm_din;
                pc_seen   = bus.dm_pc;
                addr_seen = {22'd0, bus.dm_addr};
            end
            if ((id == 0 && bus.ack0) || (id == 1 && bus.ack1)) begin
                lat = k;
                rd  = (id == 0) ? bus.rdata0 : bus.rdata1;
                check("other_ack", {31'd0, (id == 0) ? bus.ack1 : bus.ack0}, 32'd0);
                check("other_rdata", (id == 0) ? bus.rdata1 : bus.rdata0, 32'd0);
                break;
            end
        end
        set_req(id, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0, 32'd0);
        @(negedge clk);
    endtask

    logic [31:0] rd, din_seen, pc_seen, addr_seen;
    int          lat, we_cycles;
    logic [11:0] h0, h1;
    int          both;
    logic [31:0] rd0_seen, rd1_seen;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
        set_req(0, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0, 32'd0);
        set_req(1, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0, 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_ack0", {31'd0, bus.ack0}, 32'd0);
        check("rst_ack1", {31'd0, bus.ack1}, 32'd0);
        check("rst_dm_we", {31'd0, bus.dm_we}, 32'd0);
        check("rst_dm_addr", {22'd0, bus.dm_addr}, 32'd0);
        check("rst_dm_din", bus.dm_din, 32'd0);
        check("rst_dm_pc", bus.dm_pc, 32'd0);
        check("rst_state", {30'd0, bus.fsm_state}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Plain read of word 4
        mem[4] = 32'h11223344;
        access(0, 1'b0, 32'h0000_0010, 4'hF, 32'd0, 32'h0000_1000, rd, lat, we_cycles, din_seen, pc_seen, addr_seen);
        check("rd_latency", lat, 2);
        check("rd_data", rd, 32'h11223344);
        check("rd_no_we", we_cycles, 0);

        // Full-word write to word 8
        access(0, 1'b1, 32'h0000_0020, 4'hF, 32'hDEADBEEF, 32'h0000_3000, rd, lat, we_cycles, din_seen, pc_seen, addr_seen);
        check("wr_latency", lat, 2);
        check("wr_we_cycles", we_cycles, 1);
        check("wr_dm_addr", addr_seen, 32'd8);
        check("wr_dm_din", din_seen, 32'hDEADBEEF);
        check("wr_dm_pc", pc_seen, 32'h0000_3000);
        check("wr_mem", mem[8], 32'hDEADBEEF);
        check("hold_dm_din", bus.dm_din, 32'hDEADBEEF);
        check("hold_dm_addr", {22'd0, bus.dm_addr}, 32'd8);

        // Read back through requester 1
        access(1, 1'b0, 32'h0000_0020, 4'h1, 32'd0, 32'h0000_2000, rd, lat, we_cycles, din_seen, pc_seen, addr_seen);
        check("rb1_latency", lat, 2);
        check("rb1_data", rd, 32'hDEADBEEF);

        // Byte-lane write: only byte 1 replaced, rdata is the pre-write word
        access(0, 1'b1, 32'h0000_0020, 4'b0010, 32'h0000AB00, 32'h0000_3004, rd, lat, we_cycles, din_seen, pc_seen, addr_seen);
        check("be_dm_din", din_seen, 32'hDEADABEF);
        check("be_rdata_prewrite", rd, 32'hDEADBEEF);
        check("be_mem", mem[8], 32'hDEADABEF);

        // be = 0 write: completes, never writes
        mem[12] = 32'h55AA55AA;
        access(1, 1'b1, 32'h0000_0030, 4'b0000, 32'hFFFFFFFF, 32'h0000_3008, rd, lat, we_cycles, din_seen, pc_seen, addr_seen);
        check("be0_latency", lat, 2);
        check("be0_no_we", we_cycles, 0);
        check("be0_mem", mem[12], 32'h55AA55AA);

        // Upper and low address bits ignored: 0xFFFFF013 selects word 4
        access(0, 1'b0, 32'hFFFF_F013, 4'h0, 32'd0, 32'd0, rd, lat, we_cycles, din_seen, pc_seen, addr_seen);
        check("addr_wrap_data", rd, 32'h11223344);

        // Both requesters held from reset: strict alternation, 0 first
        mem[1] = 32'hA0A0A0A0;
        mem[2] = 32'hB1B1B1B1;
        reset = 1'b1;
        set_req(0, 1'b1, 1'b0, 32'h0000_0004, 4'hF, 32'd0, 32'd0);
        set_req(1, 1'b1, 1'b0, 32'h0000_0008, 4'hF, 32'd0, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        h0 = 12'd0; h1 = 12'd0; both = 0; rd0_seen = 0; rd1_seen = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            h0[k-1] = bus.ack0;
            h1[k-1] = bus.ack1;
            if (bus.ack0 && bus.ack1) both++;
            if (k == 2) rd0_seen = bus.rdata0;
            if (k == 5) rd1_seen = bus.rdata1;
        end
        check("alt_ack0_pattern", {20'd0, h0}, 32'h082);
        check("alt_ack1_pattern", {20'd0, h1}, 32'h410);
        check("alt_both_acks", both, 0);
        check("alt_rdata0", rd0_seen, 32'hA0A0A0A0);
        check("alt_rdata1", rd1_seen, 32'hB1B1B1B1);
        set_req(0, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0, 32'd0);
        set_req(1, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset during SERVE of a write
        mem[20] = 32'h12345678;
        set_req(0, 1'b1, 1'b1, 32'h0000_0050, 4'hF, 32'hCAFEF00D, 32'h0000_4000);
        set_req(1, 1'b1, 1'b0, 32'h0000_0040, 4'hF, 32'd0, 32'h0000_5000);
        @(negedge clk);
        check("mid_serve_we", {31'd0, bus.dm_we}, 32'd1);
        check("mid_serve_state", {30'd0, bus.fsm_state}, 32'd1);
        reset = 1'b1;
        #1;
        check("mid_we_in_reset", {31'd0, bus.dm_we}, 32'd0);
        @(negedge clk);
        check("mid_mem_kept", mem[20], 32'h12345678);
        check("mid_no_ack0", {31'd0, bus.ack0}, 32'd0);
        check("mid_dm_din_clr", bus.dm_din, 32'd0);
        check("mid_dm_pc_clr", bus.dm_pc, 32'd0);
        check("mid_state_idle", {30'd0, bus.fsm_state}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("post_serve_ack0", {31'd0, bus.ack0}, 32'd0);
        @(negedge clk);
        check("post_ack0", {31'd0, bus.ack0}, 32'd1);
        check("post_ack1", {31'd0, bus.ack1}, 32'd0);
        set_req(0, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0, 32'd0);
        set_req(1, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0, 32'd0);
        @(negedge clk);
        check("post_mem_written", mem[20], 32'hCAFEF00D);
        check("post_idle_we", {31'd0, bus.dm_we}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
